// File: rtl/calc1_port_responder.sv
// calc1 single-port responder: takes a command with operand 1, then operand 2, and
// answers with a one-cycle response code and result LATENCY + 1 cycles after the command.
module calc1_port_responder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [3:0] CmdAdd = 4'd1;
    localparam logic [3:0] CmdSub = 4'd2;
    localparam logic [3:0] CmdShl = 4'd5;
    localparam logic [3:0] CmdShr = 4'd6;

    localparam logic [1:0] RespNone = 2'd0;
    localparam logic [1:0] RespOk   = 2'd1;
    localparam logic [1:0] RespErr  = 2'd2;

    typedef enum logic [1:0] {StIdle, StOp2, StExec, StResp} state_e;

    state_e            state_q;
    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] res_q;
    logic [1:0]        code_q;
    logic [CntW-1:0]   cnt_q;
    logic [1:0]        out_resp_q;
    logic [DATA_W-1:0] out_data_q;
    logic              busy_q;
    logic              proto_err_q;

    logic [DATA_W-1:0] res_d;
    logic [1:0]        code_d;
    logic [DATA_W:0]   sum;

    // Operand 2 is taken straight from the bus in the OP2 cycle.
    always_comb begin
        res_d  = '0;
        code_d = RespErr;
        sum    = {1'b0, op1_q} + {1'b0, req_data_in};
        case (cmd_q)
            CmdAdd: begin
                if (!sum[DATA_W]) begin
                    code_d = RespOk;
                    res_d  = sum[DATA_W-1:0];
                end
            end
            CmdSub: begin
                if (req_data_in <= op1_q) begin
                    code_d = RespOk;
                    res_d  = op1_q - req_data_in;
                end
            end
            CmdShl: begin
                code_d = RespOk;
                res_d  = op1_q << req_data_in[SHAMT_W-1:0];
            end
            CmdShr: begin
                code_d = RespOk;
                res_d  = op1_q >> req_data_in[SHAMT_W-1:0];
            end
            default: begin
                code_d = RespErr;
                res_d  = '0;
            end
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            op1_q       <= '0;
            res_q       <= '0;
            code_q      <= RespNone;
            cnt_q       <= '0;
            out_resp_q  <= RespNone;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            out_resp_q <= RespNone;
            out_data_q <= '0;
            if (state_q != StIdle && req_cmd_in != 4'd0) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (req_cmd_in != 4'd0) begin
                        cmd_q   <= req_cmd_in;
                        op1_q   <= req_data_in;
                        busy_q  <= 1'b1;
                        state_q <= StOp2;
                    end
                end
                StOp2: begin
                    res_q  <= res_d;
                    code_q <= code_d;
                    if (LATENCY <= 1) begin
                        out_resp_q <= code_d;
                        out_data_q <= res_d;
                        state_q    <= StResp;
                    end else begin
                        cnt_q   <= CntW'(LATENCY - 1);
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    cnt_q <= cnt_q - 1'b1;
                    // Counter reaching zero on this edge means the response cycle is next.
                    if (cnt_q == CntW'(1)) begin
                        out_resp_q <= code_q;
                        out_data_q <= res_q;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_resp  = out_resp_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder: directed vector table, random ops against an
// arithmetic reference model, plus protocol-error and reset-abort sequences.
module tb_calc1_port_responder;

    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 3;

    logic          c_clk;
    logic          reset;
    logic [3:0]    req_cmd_in;
    logic [DW-1:0] req_data_in;
    logic [1:0]    out_resp;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    calc1_port_responder #(
        .DATA_W (DW),
        .LATENCY(LAT),
        .SHAMT_W(5)
    ) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .out_resp   (out_resp),
        .out_data   (out_data),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the command's meaning.
    function automatic void model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b, output logic [1:0] r,
                                  output logic [31:0] d);
        longint unsigned la, lb, s, p;
        la = 64'(a);
        lb = 64'(b);
        p  = 64'd1 << (lb % 64'd32);
        r  = 2'd2;
        d  = '0;
        case (c)
            4'd1: begin
                s = la + lb;
                if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (lb <= la) begin s = la - lb; r = 2'd1; d = s[31:0]; end
            4'd5: begin s = (la * p) % 64'h1_0000_0000; r = 2'd1; d = s[31:0]; end
            4'd6: begin s = la / p; r = 2'd1; d = s[31:0]; end
            default: begin r = 2'd2; d = '0; end
        endcase
    endfunction

    // Issues one op at the next negedge; ends at the response cycle. The idle checks at
    // the start make consecutive calls back-to-back (cmd in the cycle after RESP).
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed, input string nm);
        @(negedge c_clk);
        chk({nm, " idle busy"}, 32'(busy), 32'd0);
        chk({nm, " idle resp"}, 32'(out_resp), 32'd0);
        req_cmd_in  = c;
        req_data_in = a;
        @(negedge c_clk);
        chk({nm, " busy op2"}, 32'(busy), 32'd1);
        req_cmd_in  = 4'd0;
        req_data_in = b;
        for (int k = 2; k <= int'(LAT); k++) begin
            @(negedge c_clk);
            req_data_in = $urandom;
            chk({nm, " early resp"}, 32'(out_resp), 32'd0);
            chk({nm, " busy exec"}, 32'(busy), 32'd1);
        end
        @(negedge c_clk);
        chk({nm, " resp"}, 32'(out_resp), 32'(er));
        chk({nm, " data"}, out_data, ed);
        chk({nm, " busy resp"}, 32'(busy), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b, ed;
        logic [1:0]  er;

        vecs.push_back('{4'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C, "add 5+7"});
        vecs.push_back('{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0, "add ovf"});
        vecs.push_back('{4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF, "add max"});
        vecs.push_back('{4'd2, 32'h0000_0010, 32'h0000_0010, 2'd1, 32'h0, "sub eq"});
        vecs.push_back('{4'd2, 32'h0000_0003, 32'h0000_0004, 2'd2, 32'h0, "sub unf"});
        vecs.push_back('{4'd2, 32'h0000_0100, 32'h0000_0001, 2'd1, 32'h0000_00FF, "sub ok"});
        vecs.push_back('{4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000, "shl 31"});
        vecs.push_back('{4'd5, 32'h0000_0001, 32'h0000_0020, 2'd1, 32'h0000_0001, "shl 32"});
        vecs.push_back('{4'd5, 32'hF000_000F, 32'h0000_0004, 2'd1, 32'h0000_00F0, "shl drop"});
        vecs.push_back('{4'd6, 32'h8000_0000, 32'h0000_0021, 2'd1, 32'h4000_0000, "shr 0x21"});
        vecs.push_back('{4'd4, 32'h1234_5678, 32'h9ABC_DEF0, 2'd2, 32'h0, "cmd 4"});
        vecs.push_back('{4'd1, 32'h0000_0002, 32'h0000_0003, 2'd1, 32'h0000_0005, "b2b add"});
        vecs.push_back('{4'd15, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0, "cmd 15"});
        vecs.push_back('{4'd3, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0, "cmd 3"});

        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = '0;
        repeat (3) @(negedge c_clk);
        chk("rst resp", 32'(out_resp), 32'd0);
        chk("rst data", out_data, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst perr", 32'(proto_err), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].cmd, vecs[i].op1, vecs[i].op2, vecs[i].resp, vecs[i].data,
                  vecs[i].name);
        end

        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom_range(1, 15));
            if (i % 3 == 0) c = 4'($urandom_range(1, 2));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? a : $urandom;
            model(c, a, b, er, ed);
            do_op(c, a, b, er, ed, $sformatf("rnd%0d c%0d", i, c));
        end
        chk("perr clean", 32'(proto_err), 32'd0);

        // Command driven during EXEC: flagged, but the in-flight add is untouched.
        @(negedge c_clk);
        req_cmd_in  = 4'd1;
        req_data_in = 32'h0000_0100;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = 32'h0000_0023;
        @(negedge c_clk);
        req_cmd_in  = 4'd2;
        req_data_in = 32'hDEAD_BEEF;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        chk("perr set", 32'(proto_err), 32'd1);
        chk("perr no early resp", 32'(out_resp), 32'd0);
        @(negedge c_clk);
        chk("perr add resp", 32'(out_resp), 32'd1);
        chk("perr add data", out_data, 32'h0000_0123);
        for (int k = 0; k < 4; k++) begin
            @(negedge c_clk);
            chk("perr no 2nd resp", 32'(out_resp), 32'd0);
            chk("perr idle busy", 32'(busy), 32'd0);
            chk("perr sticky", 32'(proto_err), 32'd1);
        end

        // Reset during EXEC aborts the op with no later response.
        @(negedge c_clk);
        req_cmd_in  = 4'd1;
        req_data_in = 32'h0000_0001;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = 32'h0000_0001;
        @(negedge c_clk);
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort resp", 32'(out_resp), 32'd0);
        chk("abort data", out_data, 32'd0);
        chk("abort perr", 32'(proto_err), 32'd0);
        @(negedge c_clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge c_clk);
            chk("abort no resp", 32'(out_resp), 32'd0);
        end
        do_op(4'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C, "post-rst add");
        chk("post-rst perr", 32'(proto_err), 32'd0);
        @(negedge c_clk);
        chk("post-rst resp clr", 32'(out_resp), 32'd0);
        chk("post-rst busy clr", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calc1_port_responder.md
Name: calc1_port_responder

Overview:
Single-port responder for the calc1 request/response protocol: the counterpart to the bench-side requester that drives cmd/data.
- Accepts a command with operand 1, then operand 2 on the next cycle.
- Computes add, subtract, shift-left or shift-right.
- Returns a one-cycle response code plus result after a programmable latency.
- Used as a golden/stand-in responder and as a loopback target for requester-side agents.

Parameters:
- DATA_W, 32: operand and result width.
- LATENCY, 3: cycles from operand-2 capture to response (minimum 1).
- SHAMT_W, 5: low bits of operand 2 used as the shift amount.

Ports:
- c_clk, input, 1: clock, all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_cmd_in, input, 4: command. 0 = no-op, 1 = add, 2 = sub, 5 = shift left, 6 = shift right, other = invalid.
- req_data_in, input, DATA_W: operand 1 in the cmd cycle, operand 2 in the following cycle.
- out_resp, output, 2: 0 = none, 1 = success, 2 = overflow/underflow/invalid command, 3 = never driven.
- out_data, output, DATA_W: result; valid only when out_resp == 1, otherwise 0.
- busy, output, 1: high from cmd capture until the response cycle ends.
- proto_err, output, 1: sticky; set when a non-zero cmd arrives while busy. Cleared only by reset.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, out_resp = 0, out_data = 0, busy = 0, proto_err = 0, latency counter = 0, operand registers = 0.
- States: IDLE, OP2, EXEC, RESP.
- IDLE:
  - req_cmd_in != 0: capture cmd and operand 1; busy = 1 from the next cycle; go to OP2.
  - req_cmd_in == 0: stay in IDLE.
- OP2: capture req_data_in as operand 2 unconditionally; compute result and resp code; load counter with LATENCY-1; go to EXEC (LATENCY == 1 goes directly to RESP).
- EXEC: decrement counter; on 0 go to RESP.
- RESP: drive out_resp/out_data for exactly one cycle; next cycle out_resp = 0, out_data = 0, busy = 0, state IDLE.
- Response timing: total cmd-cycle-to-response = LATENCY + 1 cycles. A new cmd is accepted in the cycle immediately after RESP.
- Add: 33-bit sum. Carry out → resp 2, data 0. Otherwise resp 1, data = sum[DATA_W-1:0]. 0xFFFFFFFF + 1 overflows.
- Sub: op2 > op1 (unsigned) → resp 2, data 0. Otherwise resp 1, data = op1 - op2. Equal operands → resp 1, data 0.
- Shift left: op1 << op2[SHAMT_W-1:0], zero fill, bits shifted out discarded, always resp 1. Upper bits of op2 ignored, so op2 = 32 means shift 0.
- Shift right: logical, zero fill, always resp 1.
- Invalid cmd (3, 4, 7..15): operand-2 cycle still consumed; after latency resp 2, data 0.
- Non-zero cmd while busy (OP2/EXEC/RESP): ignored, in-flight operation unaffected, proto_err set. In OP2 the cmd field is ignored; data is taken as operand 2, and proto_err is still set if cmd != 0.
- Reset asserted mid-operation: operation aborted, no response ever emitted. After reset release the next cmd starts cleanly.
- out_resp and out_data are registered; no combinational path from inputs to outputs.

Test Plan:
- Add 0x00000005 + 0x00000007, LATENCY 3 → out_resp = 1, out_data = 0x0000000C exactly 4 cycles after cmd cycle, held 1 cycle. Busy high for 4 cycles.
- Add 0xFFFFFFFF + 0x00000001 → resp 2, data 0. Sub 0x10 - 0x10 → resp 1, data 0. Sub 0x3 - 0x4 → resp 2, data 0.
- Shift left 0x00000001 by 31 → 0x80000000. Shift right 0x80000000 by 0x21 → 0x40000000 (only 5 bits used). Both resp 1.
- Cmd 4 with any operands → resp 2, data 0 after same latency. Then back-to-back add issued the cycle after RESP → accepted and answered correctly.
- Add issued, then cmd 2 driven during EXEC → proto_err = 1 and stays set; original add response unchanged; no second response.
- Cmd issued, reset pulsed low during EXEC → all outputs 0 immediately, no response after release. A subsequent add completes normally with proto_err = 0.
